vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 183 ++++++++++++++++++
 tb/tb_vga_timing.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing
//
// Raster timing generator for a VGA-style display. Two free-running counters
// walk the full raster (visible area plus porches and sync); all outputs are
// decoded from the counter values that the same clock edge produces, then
// registered. The outputs therefore describe exactly the pixel that the
// counters point at, with no pipeline lag.
//
// Optional feature (macro VGA_TIMING_CE_EN):
//   When defined, the pix_ce input is added and only edges with pix_ce = 1
//   advance the raster. All counters, phase FSMs and outputs hold otherwise.
//   When undefined, every clk edge advances.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   pix_ce       in   pixel clock enable (only with VGA_TIMING_CE_EN)
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   blank_n      out  DAC blanking, low outside the visible area
//   sync_n       out  composite sync (hsync AND vsync), active low
//   disp_enable  out  high inside the visible area
//   Xpix         out  current horizontal count, zero-extended to 32 bits
//   Ypix         out  current vertical count, zero-extended to 32 bits
//   dbg_hphase_o out  horizontal phase FSM state (0 disp,1 front,2 sync,3 back)
//   dbg_vphase_o out  vertical phase FSM state (same encoding)
// ----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_disp  = 640,
    parameter int H_front = 16,
    parameter int H_sync  = 96,
    parameter int H_back  = 48,
    parameter int V_disp  = 480,
    parameter int V_front = 10,
    parameter int V_sync  = 2,
    parameter int V_back  = 33
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VGA_TIMING_CE_EN
    input  logic        pix_ce,
`endif
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        disp_enable,
    output logic [31:0] Xpix,
    output logic [31:0] Ypix,
    output logic [1:0]  dbg_hphase_o,
    output logic [1:0]  dbg_vphase_o
);

    localparam int H_TOTAL = H_disp + H_front + H_sync + H_back;
    localparam int V_TOTAL = V_disp + V_front + V_sync + V_back;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Region boundaries, kept 32 bits wide so that a boundary equal to the
    // total (zero-width back porch) cannot alias onto a small counter.
    localparam logic [31:0] H_FP_X = 32'(H_disp);
    localparam logic [31:0] H_SY_X = 32'(H_disp + H_front);
    localparam logic [31:0] H_BP_X = 32'(H_disp + H_front + H_sync);
    localparam logic [31:0] V_FP_X = 32'(V_disp);
    localparam logic [31:0] V_SY_X = 32'(V_disp + V_front);
    localparam logic [31:0] V_BP_X = 32'(V_disp + V_front + V_sync);

    typedef enum logic [1:0] {
        HDISP  = 2'd0,
        HFRONT = 2'd1,
        HSYNC  = 2'd2,
        HBACK  = 2'd3
    } hphase_e;

    typedef enum logic [1:0] {
        VDISP  = 2'd0,
        VFRONT = 2'd1,
        VSYNC  = 2'd2,
        VBACK  = 2'd3
    } vphase_e;

    logic          advance;
    logic          h_wrap;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [31:0]   xpix_d, ypix_d;
    hphase_e       hphase_q, hphase_d;
    vphase_e       vphase_q, vphase_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sync_n_q;
    logic          blank_n_q;
    logic          de_q, de_d;
    logic [31:0]   xpix_q, ypix_q;

`ifdef VGA_TIMING_CE_EN
    assign advance = pix_ce;
`else
    assign advance = 1'b1;
`endif

    // Next raster position and everything decoded from it. The registers
    // below only take these values on an advancing edge.
    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end

        xpix_d = 32'(hcnt_d);
        ypix_d = 32'(vcnt_d);

        // Later boundaries are tested first so that a zero-width region is
        // skipped rather than entered.
        hphase_d = hphase_q;
        if (xpix_d == 32'd0)      hphase_d = HDISP;
        else if (xpix_d == H_BP_X) hphase_d = HBACK;
        else if (xpix_d == H_SY_X) hphase_d = HSYNC;
        else if (xpix_d == H_FP_X) hphase_d = HFRONT;

        // The vertical phase can only change when a line wraps.
        vphase_d = vphase_q;
        if (h_wrap) begin
            if (ypix_d == 32'd0)      vphase_d = VDISP;
            else if (ypix_d == V_BP_X) vphase_d = VBACK;
            else if (ypix_d == V_SY_X) vphase_d = VSYNC;
            else if (ypix_d == V_FP_X) vphase_d = VFRONT;
        end

        de_d    = (xpix_d < H_FP_X) && (ypix_d < V_FP_X);
        hsync_d = !((xpix_d >= H_SY_X) && (xpix_d < H_BP_X));
        vsync_d = !((ypix_d >= V_SY_X) && (ypix_d < V_BP_X));
    end

    // Reset parks the counters on the last pixel of the frame so that the
    // first advancing edge lands on (0,0); the outputs are forced to an idle
    // blanked value rather than decoded from that parked position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= H_LAST;
            vcnt_q    <= V_LAST;
            hphase_q  <= HBACK;
            vphase_q  <= VBACK;
            xpix_q    <= '0;
            ypix_q    <= '0;
            de_q      <= 1'b0;
            blank_n_q <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            sync_n_q  <= 1'b1;
        end else if (advance) begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hphase_q  <= hphase_d;
            vphase_q  <= vphase_d;
            xpix_q    <= xpix_d;
            ypix_q    <= ypix_d;
            de_q      <= de_d;
            blank_n_q <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            sync_n_q  <= hsync_d & vsync_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign sync_n       = sync_n_q;
    assign blank_n      = blank_n_q;
    assign disp_enable  = de_q;
    assign Xpix         = xpix_q;
    assign Ypix         = ypix_q;
    assign dbg_hphase_o = hphase_q;
    assign dbg_vphase_o = vphase_q;

endmodule

// File: tb/tb_vga_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_timing
//
// Three instances share clk/rst: default 640x480 timing, a medium raster used
// to reach pixel (300,200) quickly, and a tiny 7x5 raster. A bench-side model
// of each raster pushes the expected output word into exp_q before every edge;
// after the edge the words are popped and compared. Directed checks against
// constants cover the line/frame boundaries.
// ----------------------------------------------------------------------------
module tb_vga_timing;

    localparam int M_HD = 304, M_HF = 4, M_HS = 8, M_HB = 4;
    localparam int M_VD = 208, M_VF = 2, M_VS = 2, M_VB = 4;
    localparam int S_HD = 4,   S_HF = 1, S_HS = 1, S_HB = 1;
    localparam int S_VD = 2,   S_VF = 1, S_VS = 1, S_VB = 1;

    typedef logic [72:0] vec_t;
    // {hphase, vphase, hsync, vsync, blank_n, sync_n, disp_enable, Xpix, Ypix}
    localparam vec_t RST_VEC = {2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

`ifdef VGA_TIMING_CE_EN
    logic pix_ce = 1'b1;
`endif

    logic        hs_w [3];
    logic        vs_w [3];
    logic        bn_w [3];
    logic        sn_w [3];
    logic        de_w [3];
    logic [31:0] x_w  [3];
    logic [31:0] y_w  [3];
    logic [1:0]  hph_w[3];
    logic [1:0]  vph_w[3];

    vga_timing u_def (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .pix_ce(pix_ce),
`endif
        .hsync(hs_w[0]), .vsync(vs_w[0]), .blank_n(bn_w[0]), .sync_n(sn_w[0]),
        .disp_enable(de_w[0]), .Xpix(x_w[0]), .Ypix(y_w[0]),
        .dbg_hphase_o(hph_w[0]), .dbg_vphase_o(vph_w[0])
    );

    vga_timing #(
        .H_disp(M_HD), .H_front(M_HF), .H_sync(M_HS), .H_back(M_HB),
        .V_disp(M_VD), .V_front(M_VF), .V_sync(M_VS), .V_back(M_VB)
    ) u_med (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .pix_ce(pix_ce),
`endif
        .hsync(hs_w[1]), .vsync(vs_w[1]), .blank_n(bn_w[1]), .sync_n(sn_w[1]),
        .disp_enable(de_w[1]), .Xpix(x_w[1]), .Ypix(y_w[1]),
        .dbg_hphase_o(hph_w[1]), .dbg_vphase_o(vph_w[1])
    );

    vga_timing #(
        .H_disp(S_HD), .H_front(S_HF), .H_sync(S_HS), .H_back(S_HB),
        .V_disp(S_VD), .V_front(S_VF), .V_sync(S_VS), .V_back(S_VB)
    ) u_small (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .pix_ce(pix_ce),
`endif
        .hsync(hs_w[2]), .vsync(vs_w[2]), .blank_n(bn_w[2]), .sync_n(sn_w[2]),
        .disp_enable(de_w[2]), .Xpix(x_w[2]), .Ypix(y_w[2]),
        .dbg_hphase_o(hph_w[2]), .dbg_vphase_o(vph_w[2])
    );

    // ---------------- scoreboard state ----------------
    vec_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    P [3][8];
    int    mh [3];
    int    mv [3];
    bit    in_rst [3];
    string NAME [3] = '{"def", "med", "small"};

    function automatic int htot(int i);
        return P[i][0] + P[i][1] + P[i][2] + P[i][3];
    endfunction

    function automatic int vtot(int i);
        return P[i][4] + P[i][5] + P[i][6] + P[i][7];
    endfunction

    // Expected output word for raster i sitting at (h, v).
    function automatic vec_t model_out(int i, int h, int v);
        int hd = P[i][0];
        int hf = P[i][1];
        int hs = P[i][2];
        int vd = P[i][4];
        int vf = P[i][5];
        int vs = P[i][6];
        logic de, hs_n, vs_n;
        logic [1:0] hp, vp;
        de   = (h < hd) && (v < vd);
        hs_n = !((h >= hd + hf) && (h < hd + hf + hs));
        vs_n = !((v >= vd + vf) && (v < vd + vf + vs));
        hp   = (h < hd) ? 2'd0 : (h < hd + hf) ? 2'd1 : (h < hd + hf + hs) ? 2'd2 : 2'd3;
        vp   = (v < vd) ? 2'd0 : (v < vd + vf) ? 2'd1 : (v < vd + vf + vs) ? 2'd2 : 2'd3;
        return {hp, vp, hs_n, vs_n, de, hs_n & vs_n, de, 32'(h), 32'(v)};
    endfunction

    function automatic vec_t obs(int i);
        return {hph_w[i], vph_w[i], hs_w[i], vs_w[i], bn_w[i], sn_w[i], de_w[i], x_w[i], y_w[i]};
    endfunction

    task automatic check(input string tag, input vec_t observed, input vec_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check(tag, {41'd0, observed}, {41'd0, expected});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            in_rst[i] = 1'b1;
            mh[i] = htot(i) - 1;
            mv[i] = vtot(i) - 1;
        end
    endtask

    // ---------------- driver ----------------
    // Push the expected word for each raster, take one edge, compare.
    task automatic step(input logic ce);
        logic adv;
`ifdef VGA_TIMING_CE_EN
        pix_ce = ce;
        adv = ce;
`else
        adv = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q.push_back(RST_VEC);
            end else begin
                if (adv) begin
                    in_rst[i] = 1'b0;
                    if (mh[i] == htot(i) - 1) begin
                        mh[i] = 0;
                        mv[i] = (mv[i] == vtot(i) - 1) ? 0 : mv[i] + 1;
                    end else begin
                        mh[i] = mh[i] + 1;
                    end
                end
                exp_q.push_back(in_rst[i] ? RST_VEC : model_out(i, mh[i], mv[i]));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty_%s observed=empty expected=entry", NAME[i]);
            end else begin
                check({"edge_", NAME[i]}, obs(i), exp_q.pop_front());
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last;
        int vs_cnt_s, hs_cnt_s, hs_bad_s, vs_bad_s;
        int budget;

        P[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
        P[1] = '{M_HD, M_HF, M_HS, M_HB, M_VD, M_VF, M_VS, M_VB};
        P[2] = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB};

        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        vs_cnt_s = 0; hs_cnt_s = 0; hs_bad_s = 0; vs_bad_s = 0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check({"reset_", NAME[i]}, obs(i), RST_VEC);

        // An edge while reset is held keeps the reset values.
        step(1'b1);

        @(negedge clk);
        rst = 1'b0;

        // One full default line; the tiny raster covers several frames.
        for (int k = 0; k < 800; k++) begin
            step(1'b1);
            if (k == 0) begin
                check32("first_xpix", x_w[0], 32'd0);
                check32("first_ypix", y_w[0], 32'd0);
                check32("first_de", {31'd0, de_w[0]}, 32'd1);
                check32("first_hsync", {31'd0, hs_w[0]}, 32'd1);
                check32("first_vsync", {31'd0, vs_w[0]}, 32'd1);
            end
            if (de_w[0]) de_cnt++;
            if (!hs_w[0]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_w[0]);
                hs_last = int'(x_w[0]);
            end
            if (k < 35) begin
                if (!vs_w[2]) begin
                    vs_cnt_s++;
                    if (y_w[2] != 32'd3) vs_bad_s++;
                end
                if (!hs_w[2]) begin
                    hs_cnt_s++;
                    if (x_w[2] != 32'd5) hs_bad_s++;
                end
            end
            if (k == 34) begin
                check32("small_last_x", x_w[2], 32'd6);
                check32("small_last_y", y_w[2], 32'd4);
            end
            if (k == 35 || k == 70) begin
                check32("small_wrap_x", x_w[2], 32'd0);
                check32("small_wrap_y", y_w[2], 32'd0);
            end
        end
        check32("line_de_count", 32'(de_cnt), 32'd640);
        check32("line_hsync_count", 32'(hs_cnt), 32'd96);
        check32("line_hsync_first", 32'(hs_first), 32'd656);
        check32("line_hsync_last", 32'(hs_last), 32'd751);
        check32("small_vsync_count", 32'(vs_cnt_s), 32'd7);
        check32("small_hsync_count", 32'(hs_cnt_s), 32'd5);
        check32("small_hsync_pos", 32'(hs_bad_s), 32'd0);
        check32("small_vsync_pos", 32'(vs_bad_s), 32'd0);

        // Line period: 800 edges after (0,0) the default raster is at (0,1).
        step(1'b1);
        check32("line_period_x", x_w[0], 32'd0);
        check32("line_period_y", y_w[0], 32'd1);

`ifdef VGA_TIMING_CE_EN
        // pix_ce toggling: one line now spans 1600 clk edges.
        for (int j = 0; j < 1600; j++) step((j % 2) == 0);
        check32("ce_line_x", x_w[0], 32'd0);
        check32("ce_line_y", y_w[0], 32'd2);
        step(1'b1);
`endif

        // Walk the medium raster to (300,200), then reset between edges.
        budget = 0;
        while (!(mh[1] == 300 && mv[1] == 200) && budget < 80000) begin
            step(1'b1);
            budget++;
        end
        if (budget >= 80000) begin
            checks++;
            errors++;
            $error("FAIL seek_timeout observed=%0d expected=<80000", budget);
        end
        check32("pre_rst_x", x_w[1], 32'd300);
        check32("pre_rst_y", y_w[1], 32'd200);

        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check({"mid_rst_", NAME[i]}, obs(i), RST_VEC);
        step(1'b1);

        @(negedge clk);
        rst = 1'b0;
        step(1'b1);
        check32("resume_x", x_w[1], 32'd0);
        check32("resume_y", y_w[1], 32'd0);
        check32("resume_de", {31'd0, de_w[1]}, 32'd1);
        for (int j = 0; j < 20; j++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
